// File: rtl/sdram_dq_path.sv
// SDRAM data-path sequencer: drives accepted write beats onto the shared DQ bus
// and captures read data CAS_LAT clocks after each READ command.
module sdram_dq_path #(
  parameter  int DATA_W  = 32,
  parameter  int CAS_LAT = 2,
  localparam int MASK_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [MASK_W-1:0] dqm,
  inout  wire  [DATA_W-1:0] dq,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                wr_accept_s;
  logic                in_flight_s;
  logic                oe_r;
  logic [DATA_W-1:0]   dq_out_r;
  logic [MASK_W-1:0]   dqm_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic [CAS_LAT:0]    rd_pipe_r;

  assign wr_accept_s = wr_req & wr_ready;
  // The top pipe stage is the rd_valid cycle itself, so it does not hold READ open.
  assign in_flight_s = |rd_pipe_r[CAS_LAT-1:0];

  assign dq       = oe_r ? dq_out_r : {DATA_W{1'bz}};
  assign dqm      = dqm_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_pipe_r[CAS_LAT];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a read command always wins over a write beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_req) begin
          state_nxt_s = ST_READ;
        end else if (wr_accept_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (rd_req) begin
          state_nxt_s = ST_READ;
        end else if (wr_accept_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_req || in_flight_s) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_TURN;
        end
      end
      ST_TURN: begin
        if (rd_req) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b1;
    case (state_r)
      ST_IDLE: begin
        wr_ready = ~rd_req;
        busy     = 1'b0;
      end
      ST_WRITE: begin
        wr_ready = ~rd_req;
        busy     = 1'b1;
      end
      ST_READ: begin
        wr_ready = 1'b0;
        busy     = 1'b1;
      end
      ST_TURN: begin
        wr_ready = 1'b0;
        busy     = 1'b1;
      end
      default: begin
        wr_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Write side: DQ drive value, output enable and byte mask for the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oe_r     <= 1'b0;
      dq_out_r <= {DATA_W{1'b0}};
      dqm_r    <= {MASK_W{1'b1}};
    end else begin
      oe_r <= wr_accept_s;
      if (wr_accept_s) begin
        dq_out_r <= wr_data;
        dqm_r    <= wr_mask;
      end else if (rd_req) begin
        dq_out_r <= dq_out_r;
        dqm_r    <= {MASK_W{1'b0}};
      end else begin
        dq_out_r <= dq_out_r;
        dqm_r    <= {MASK_W{1'b1}};
      end
    end
  end

  // Read side: one valid bit per READ command; dq is sampled only at capture edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pipe_r <= {(CAS_LAT+1){1'b0}};
      rd_data_r <= {DATA_W{1'b0}};
    end else begin
      rd_pipe_r <= {rd_pipe_r[CAS_LAT-1:0], rd_req};
      if (rd_pipe_r[CAS_LAT-1]) begin
        rd_data_r <= dq;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

endmodule

// File: tb/tb_sdram_dq_path.sv
// Directed bench for sdram_dq_path: a 32-bit CAS-2 instance carries the main
// scenarios, a 64-bit CAS-3 instance covers the parameter sweep.
module tb_sdram_dq_path;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        wr_req, rd_req, wr_ready, rd_valid, busy;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  wr_mask, dqm;
  wire  [31:0] dq;
  logic        dq_en;
  logic [31:0] dq_val;
  assign dq = dq_en ? dq_val : {32{1'bz}};

  logic        wr_req64, rd_req64, wr_ready64, rd_valid64, busy64;
  logic [63:0] wr_data64, rd_data64;
  logic [7:0]  wr_mask64, dqm64;
  wire  [63:0] dq64;
  logic        dq_en64;
  logic [63:0] dq_val64;
  assign dq64 = dq_en64 ? dq_val64 : {64{1'bz}};

  int cyc;
  int n_checks;
  int n_errors;

  sdram_dq_path #(.DATA_W(32), .CAS_LAT(2)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_ready(wr_ready), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .dqm(dqm), .dq(dq), .busy(busy)
  );

  sdram_dq_path #(.DATA_W(64), .CAS_LAT(3)) dut64 (
    .clk(clk), .reset(reset), .wr_req(wr_req64), .wr_data(wr_data64), .wr_mask(wr_mask64),
    .wr_ready(wr_ready64), .rd_req(rd_req64), .rd_data(rd_data64), .rd_valid(rd_valid64),
    .dqm(dqm64), .dq(dq64), .busy(busy64)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc = -100;
    reset = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; wr_data = 32'h0; wr_mask = 4'h0; dq_en = 1'b0; dq_val = 32'h0;
    wr_req64 = 1'b0; rd_req64 = 1'b0; wr_data64 = 64'h0; wr_mask64 = 8'h0;
    dq_en64 = 1'b0; dq_val64 = 64'h0;

    // Reset takes effect before the first clock edge.
    #2 reset = 1'b1;
    #1;
    check_eq("rst_dqm", {60'h0, dqm}, 64'hF);
    check_eq("rst_rd_valid", {63'h0, rd_valid}, 64'h0);
    check_eq("rst_rd_data", {32'h0, rd_data}, 64'h0);
    check_eq("rst_oe", {63'h0, dut.oe_r}, 64'h0);
    check_eq("rst_busy", {63'h0, busy}, 64'h0);
    check_eq("rst_dqm64", {56'h0, dqm64}, 64'hFF);

    @(posedge clk);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
    @(negedge clk);
    check_eq("wr_ready_after_reset", {63'h0, wr_ready}, 64'h1);

    // Single write.
    goto(5);
    wr_req = 1'b1; wr_data = 32'hA5A5_1234; wr_mask = 4'b0010;
    @(negedge clk);
    check_eq("wr_ready_idle", {63'h0, wr_ready}, 64'h1);
    goto(6);
    wr_req = 1'b0;
    @(negedge clk);
    check_eq("wr_dq", {32'h0, dq}, 64'hA5A5_1234);
    check_eq("wr_dqm", {60'h0, dqm}, 64'h2);
    check_eq("wr_oe", {63'h0, dut.oe_r}, 64'h1);
    check_eq("wr_busy", {63'h0, busy}, 64'h1);
    goto(7);
    @(negedge clk);
    check_eq("wr_oe_off", {63'h0, dut.oe_r}, 64'h0);
    check_eq("wr_dqm_idle", {60'h0, dqm}, 64'hF);
    check_eq("wr_busy_off", {63'h0, busy}, 64'h0);

    // Read burst: commands 10-13, model data 12-15, valid 13-16.
    for (int c = 10; c <= 16; c++) begin
      goto(c);
      rd_req = (c <= 13);
      dq_en  = (c >= 12 && c <= 15);
      dq_val = 32'h10 + 32'(c - 12);
      @(negedge clk);
      check_eq("burst_valid", {63'h0, rd_valid}, (c >= 13) ? 64'h1 : 64'h0);
      if (c >= 13) check_eq("burst_data", {32'h0, rd_data}, 64'h10 + 64'(c - 13));
      if (c == 10) check_eq("burst_wr_ready", {63'h0, wr_ready}, 64'h0);
      if (c == 11) check_eq("burst_dqm_zero", {60'h0, dqm}, 64'h0);
    end
    goto(17);
    dq_en = 1'b0;
    @(negedge clk);
    check_eq("turn_valid", {63'h0, rd_valid}, 64'h0);
    check_eq("turn_hold", {32'h0, rd_data}, 64'h13);
    check_eq("turn_busy", {63'h0, busy}, 64'h1);
    check_eq("turn_wr_ready", {63'h0, wr_ready}, 64'h0);
    check_eq("turn_dqm", {60'h0, dqm}, 64'hF);
    goto(18);
    @(negedge clk);
    check_eq("post_turn_wr_ready", {63'h0, wr_ready}, 64'h1);
    check_eq("post_turn_busy", {63'h0, busy}, 64'h0);

    // Collision: read wins, write is refused.
    goto(20);
    rd_req = 1'b1; wr_req = 1'b1; wr_data = 32'hDEAD_BEEF; wr_mask = 4'h0;
    @(negedge clk);
    check_eq("coll_wr_ready", {63'h0, wr_ready}, 64'h0);
    goto(21);
    rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    check_eq("coll_oe", {63'h0, dut.oe_r}, 64'h0);
    check_eq("coll_busy", {63'h0, busy}, 64'h1);
    check_eq("coll_dqm", {60'h0, dqm}, 64'h0);
    goto(22);
    dq_en = 1'b1; dq_val = 32'h0000_0077;
    goto(23);
    dq_en = 1'b0;
    @(negedge clk);
    check_eq("coll_valid", {63'h0, rd_valid}, 64'h1);
    check_eq("coll_data", {32'h0, rd_data}, 64'h77);

    // Write then read.
    goto(30);
    wr_req = 1'b1; wr_data = 32'h1111_0001; wr_mask = 4'h0;
    goto(31);
    wr_data = 32'h2222_0002; wr_mask = 4'b1000;
    @(negedge clk);
    check_eq("wtr_wr_ready", {63'h0, wr_ready}, 64'h1);
    check_eq("wtr_dq1", {32'h0, dq}, 64'h1111_0001);
    goto(32);
    wr_req = 1'b0; rd_req = 1'b1;
    @(negedge clk);
    check_eq("wtr_dq2", {32'h0, dq}, 64'h2222_0002);
    check_eq("wtr_dqm2", {60'h0, dqm}, 64'h8);
    goto(33);
    rd_req = 1'b0;
    @(negedge clk);
    check_eq("wtr_oe_off", {63'h0, dut.oe_r}, 64'h0);
    check_eq("wtr_dqm_rd", {60'h0, dqm}, 64'h0);
    goto(34);
    dq_en = 1'b1; dq_val = 32'hCAFE_0034;
    @(negedge clk);
    check_eq("wtr_valid_early", {63'h0, rd_valid}, 64'h0);
    goto(35);
    dq_en = 1'b0;
    @(negedge clk);
    check_eq("wtr_valid", {63'h0, rd_valid}, 64'h1);
    check_eq("wtr_data", {32'h0, rd_data}, 64'hCAFE_0034);

    // Reset in the middle of a read.
    goto(40);
    rd_req = 1'b1;
    goto(41);
    rd_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_oe", {63'h0, dut.oe_r}, 64'h0);
    check_eq("mid_rst_dqm", {60'h0, dqm}, 64'hF);
    check_eq("mid_rst_busy", {63'h0, busy}, 64'h0);
    @(negedge clk) reset = 1'b0;
    goto(42);
    dq_en = 1'b1; dq_val = 32'hBAD0_0042;
    @(negedge clk);
    check_eq("mid_rst_wr_ready", {63'h0, wr_ready}, 64'h1);
    for (int c = 42; c <= 45; c++) begin
      goto(c);
      if (c > 42) dq_en = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_no_valid", {63'h0, rd_valid}, 64'h0);
    end
    check_eq("mid_rst_data", {32'h0, rd_data}, 64'h0);

    // Parameter sweep: 64-bit bus, CAS latency 3; command at 50 is the sweep's cycle 5.
    goto(50);
    rd_req64 = 1'b1;
    @(negedge clk);
    check_eq("p64_idle_oe", {63'h0, dut64.oe_r}, 64'h0);
    check_eq("p64_idle_dqm", {56'h0, dqm64}, 64'hFF);
    goto(51);
    rd_req64 = 1'b0;
    @(negedge clk);
    check_eq("p64_dqm_rd", {56'h0, dqm64}, 64'h0);
    goto(53);
    dq_en64 = 1'b1; dq_val64 = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    check_eq("p64_valid_early", {63'h0, rd_valid64}, 64'h0);
    goto(54);
    dq_en64 = 1'b0;
    @(negedge clk);
    check_eq("p64_valid", {63'h0, rd_valid64}, 64'h1);
    check_eq("p64_data", rd_data64, 64'h0123_4567_89AB_CDEF);
    goto(55);
    @(negedge clk);
    check_eq("p64_valid_late", {63'h0, rd_valid64}, 64'h0);
    goto(58);
    wr_req64 = 1'b1; wr_data64 = 64'hFEDC_BA98_7654_3210; wr_mask64 = 8'hA5;
    @(negedge clk);
    check_eq("p64_wr_ready", {63'h0, wr_ready64}, 64'h1);
    goto(59);
    wr_req64 = 1'b0;
    @(negedge clk);
    check_eq("p64_wr_dq", dq64, 64'hFEDC_BA98_7654_3210);
    check_eq("p64_wr_dqm", {56'h0, dqm64}, 64'hA5);
    goto(60);
    @(negedge clk);
    check_eq("p64_oe_off", {63'h0, dut64.oe_r}, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
